// File: rtl/key_pkg.sv
// Shared types and default timing for the button conditioner (key_repeat_ctrl).
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REPEAT,
        RELEASE_CHK
    } key_state_t;

    localparam int unsigned CLK_HZ   = 50_000_000;
    localparam int unsigned DEB_MS   = 20;
    localparam int unsigned DELAY_MS = 300;
    localparam int unsigned RATE_MS  = 50;
    localparam int unsigned LONG_MS  = 1000;

    function automatic int unsigned cycles_from_ms(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser; RST_VAL is the level both flops take on reset.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/key_repeat_ctrl.sv
// Button conditioner: sync, debounce, press/release/step pulses with auto-repeat.
// Optional long-press pulse built only when KEY_LONG_PRESS_EN is defined.
module key_repeat_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = cycles_from_ms(DEB_MS),
    parameter int unsigned DELAY_CYCLES = cycles_from_ms(DELAY_MS),
    parameter int unsigned RATE_CYCLES  = cycles_from_ms(RATE_MS),
    parameter int unsigned LONG_CYCLES  = cycles_from_ms(LONG_MS),
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_step,
    output logic key_long
);

    localparam int unsigned MAX_DD = (DEB_CYCLES > DELAY_CYCLES) ? DEB_CYCLES : DELAY_CYCLES;
    localparam int unsigned MAX_DR = (MAX_DD > RATE_CYCLES) ? MAX_DD : RATE_CYCLES;
    localparam int unsigned MAXC   = (MAX_DR > LONG_CYCLES) ? MAX_DR : LONG_CYCLES;
    localparam int unsigned CW     = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(RATE_CYCLES - 1);

    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          step_q, step_d;
    logic          key_sync;
    logic          pressed_s;

    sync_2ff #(
        .RST_VAL(ACTIVE_LOW)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (key_in),
        .q_o  (key_sync)
    );

    assign pressed_s = key_sync ^ ACTIVE_LOW;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        step_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed_s) state_d = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!pressed_s) begin
                    state_d = RELEASE_CHK;
                end else if (cnt_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REPEAT: begin
                if (!pressed_s) begin
                    state_d = RELEASE_CHK;
                end else if (cnt_q == RATE_LAST) begin
                    step_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE_CHK: begin
                if (pressed_s) begin
                    state_d = HELD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Every transition restarts the shared counter for the next state's timing.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_step    = step_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LW = $clog2(LONG_CYCLES) + 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] long_cnt_q;
    logic          long_armed_q;
    logic          long_q;

    // Armed by the press, disarmed after firing once; only a new press re-arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            long_cnt_q   <= '0;
            long_armed_q <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (press_d) begin
                long_cnt_q   <= '0;
                long_armed_q <= 1'b1;
            end else if (release_d) begin
                long_armed_q <= 1'b0;
            end else if (level_q && long_armed_q) begin
                if (long_cnt_q == LONG_LAST) begin
                    long_q       <= 1'b1;
                    long_armed_q <= 1'b0;
                end else begin
                    long_cnt_q <= long_cnt_q + LW'(1);
                end
            end
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed self-checking bench for key_repeat_ctrl (DEB=4, DELAY=10, RATE=3, LONG=20).
module tb_key_repeat_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic key_in;
    logic key_level, key_press, key_release, key_step, key_long;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    key_repeat_ctrl #(
        .DEB_CYCLES  (4),
        .DELAY_CYCLES(10),
        .RATE_CYCLES (3),
        .LONG_CYCLES (20),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_step   (key_step),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic lvl, input logic pr,
                           input logic rl, input logic st, input logic lg);
        chk({tag, ".level"},   key_level,   lvl);
        chk({tag, ".press"},   key_press,   pr);
        chk({tag, ".release"}, key_release, rl);
        chk({tag, ".step"},    key_step,    st);
        chk({tag, ".long"},    key_long,    lg);
    endtask

    logic exp_step;
    logic exp_long;

    initial begin
        reset  = 1'b1;
        key_in = 1'b1;
        repeat (3) tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk_all("idle", 0, 0, 0, 0, 0);

        // press: E0 is the next edge, pulse visible after edge E0+6
        key_in = 1'b0;
        tick();
        repeat (5) begin
            tick();
            chk_all("deb_wait", 0, 0, 0, 0, 0);
        end
        tick();
        chk_all("press", 1, 1, 0, 1, 0);
        tick();
        chk_all("press_after", 1, 0, 0, 0, 0);

        key_in = 1'b1;
        tick();
        repeat (5) begin
            tick();
            chk_all("rel_wait", 1, 0, 0, 0, 0);
        end
        tick();
        chk_all("release", 0, 0, 1, 0, 0);
        tick();
        chk_all("release_after", 0, 0, 0, 0, 0);

        // 3-cycle bounce is rejected
        key_in = 1'b0;
        repeat (3) tick();
        key_in = 1'b1;
        repeat (10) begin
            tick();
            chk_all("bounce", 0, 0, 0, 0, 0);
        end

        // long hold: steps at +0, +10, +13, ...
        key_in = 1'b0;
        tick();
        repeat (6) tick();
        for (int k = 0; k <= 40; k++) begin
            if (k != 0) tick();
            exp_step = (k == 0) || (k >= 10 && ((k - 10) % 3) == 0);
`ifdef KEY_LONG_PRESS_EN
            exp_long = (k == 20);
`else
            exp_long = 1'b0;
`endif
            chk_all($sformatf("hold_k%0d", k), 1, (k == 0), 0, exp_step, exp_long);
        end

        // release with a 2-cycle re-press glitch inside RELEASE_CHK
        key_in = 1'b1;
        repeat (3) begin
            tick();
            chk_all("rel_glitch_a", 1, 0, 0, 0, 0);
        end
        key_in = 1'b0;
        repeat (2) begin
            tick();
            chk_all("rel_glitch_b", 1, 0, 0, 0, 0);
        end
        key_in = 1'b1;
        tick();
        chk_all("rel_clean_e0", 1, 0, 0, 0, 0);
        repeat (5) begin
            tick();
            chk_all("rel_clean_wait", 1, 0, 0, 0, 0);
        end
        tick();
        chk_all("rel_clean", 0, 0, 1, 0, 0);
        tick();
        chk_all("rel_clean_after", 0, 0, 0, 0, 0);

        // reset while in REPEAT
        key_in = 1'b0;
        tick();
        repeat (6) tick();
        chk_all("press2", 1, 1, 0, 1, 0);
        repeat (11) tick();
        reset = 1'b1;
        tick();
        chk_all("mid_reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        repeat (5) begin
            tick();
            chk_all("post_reset_wait", 0, 0, 0, 0, 0);
        end
        tick();
        chk_all("press3", 1, 1, 0, 1, 0);

        key_in = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
